// File: rtl/bp_update_if.sv
// Resolve-side handshake between the execute lanes and the predictor update scheduler.
// Lane 0 carries the older branch; the producer holds res_valid while res_ready is low.
interface bp_update_if #(
  parameter int GHR_W = 14,
  parameter int IDX_W = 12
);
  logic [1:0]       res_valid;
  logic [IDX_W-1:0] res_idx0;
  logic [IDX_W-1:0] res_idx1;
  logic [1:0]       res_taken;
  logic [1:0]       res_mispred;
  logic [GHR_W-1:0] res_ghr0;
  logic [GHR_W-1:0] res_ghr1;
  logic             res_ready;

  modport master (
    output res_valid, res_idx0, res_idx1, res_taken, res_mispred, res_ghr0, res_ghr1,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx0, res_idx1, res_taken, res_mispred, res_ghr0, res_ghr1,
    output res_ready
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Global-history predictor trainer: in-order update FIFO, serialized PHT read-modify-write,
// and the speculative GHR with shift-on-predict and checkpoint repair on mispredict.
module bp_update_scheduler #(
  parameter int GHR_W = 14,
  parameter int IDX_W = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic [GHR_W-1:0] ghr,
  bp_update_if.slave       res,
  output logic             pht_rd_en,
  output logic [IDX_W-1:0] pht_rd_idx,
  input  logic [1:0]       pht_rd_data,
  output logic             pht_wr_en,
  output logic [IDX_W-1:0] pht_wr_idx,
  output logic [1:0]       pht_wr_data,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] fifo_idx [DEPTH];
  logic [DEPTH-1:0] fifo_taken;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next, n_push;
  logic             push0, push1, pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
  endfunction

  // Ready is taken from the registered count only, so a same-cycle pop never raises it.
  assign res.res_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign push0      = res.res_ready & res.res_valid[0];
  assign push1      = res.res_ready & res.res_valid[1];
  assign pop        = (state == S_WRITE);
  assign n_push     = CNT_W'(push0) + CNT_W'(push1);
  assign count_next = count + n_push - CNT_W'(pop);
  assign head_idx   = fifo_idx[rd_ptr];
  assign head_taken = fifo_taken[rd_ptr];
  assign busy       = (count != '0) || (state != S_IDLE);

  // Entry storage carries no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push0) begin
      fifo_idx[wr_ptr]   <= res.res_idx0;
      fifo_taken[wr_ptr] <= res.res_taken[0];
    end
    if (push1) begin
      fifo_idx[wr_ptr + PTR_W'(push0)]   <= res.res_idx1;
      fifo_taken[wr_ptr + PTR_W'(push0)] <= res.res_taken[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count_next;
    end
  end

  always_comb begin
    state_next  = state;
    pht_rd_en   = 1'b0;
    pht_rd_idx  = '0;
    pht_wr_en   = 1'b0;
    pht_wr_idx  = '0;
    pht_wr_data = 2'b00;
    case (state)
      S_IDLE: begin
        if (count != '0) state_next = S_READ;
      end
      S_READ: begin
        pht_rd_en  = 1'b1;
        pht_rd_idx = head_idx;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        pht_wr_en   = 1'b1;
        pht_wr_idx  = head_idx;
        pht_wr_data = sat_update(pht_rd_data, head_taken);
        state_next  = (count_next != '0) ? S_READ : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Older lane's repair wins; any repair overrides a same-cycle predict shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else if (push0 && res.res_mispred[0]) begin
      ghr <= {res.res_ghr0[GHR_W-2:0], res.res_taken[0]};
    end else if (push1 && res.res_mispred[1]) begin
      ghr <= {res.res_ghr1[GHR_W-2:0], res.res_taken[1]};
    end else if (pred_valid) begin
      ghr <= {ghr[GHR_W-2:0], pred_taken};
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios followed by random resolve/predict traffic,
// all checked against an in-order queue/table reference model.
module tb_bp_update_scheduler;
  localparam int GHR_W = 14;
  localparam int IDX_W = 12;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pred_valid = 1'b0;
  logic             pred_taken = 1'b0;
  logic [GHR_W-1:0] ghr;
  logic             pht_rd_en, pht_wr_en, busy;
  logic [IDX_W-1:0] pht_rd_idx, pht_wr_idx;
  logic [1:0]       pht_rd_data = 2'b00;
  logic [1:0]       pht_wr_data;

  logic             pl_en = 1'b0;
  logic [IDX_W-1:0] pl_idx = '0;
  logic [1:0]       pl_val = 2'b00;

  bp_update_if #(.GHR_W(GHR_W), .IDX_W(IDX_W)) rif();

  bp_update_scheduler #(.GHR_W(GHR_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .ghr(ghr),
    .res(rif), .pht_rd_en(pht_rd_en), .pht_rd_idx(pht_rd_idx), .pht_rd_data(pht_rd_data),
    .pht_wr_en(pht_wr_en), .pht_wr_idx(pht_wr_idx), .pht_wr_data(pht_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pattern-history table environment: synchronous read, plus a preload path.
  bit [1:0] env_pht [1 << IDX_W];
  always @(posedge clk) begin
    if (pht_rd_en) pht_rd_data <= env_pht[pht_rd_idx];
    if (pht_wr_en) env_pht[pht_wr_idx] <= pht_wr_data;
    if (pl_en)     env_pht[pl_idx] <= pl_val;
  end

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } ent_t;

  ent_t             q[$];
  bit [1:0]         ref_pht [1 << IDX_W];
  logic [GHR_W-1:0] ref_ghr = '0;
  int               n_vec = 0;
  int               n_err = 0;
  int               n_wr = 0;
  int               stall = 0;
  logic             prev_rd = 1'b0;
  logic             m_ready;
  ent_t             e, e_new;
  logic [1:0]       exp_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] ref_train(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // Reference model: evaluated mid-cycle, then advanced to what the next edge should produce.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      ref_ghr = '0;
      prev_rd = 1'b0;
      stall   = 0;
    end else begin
      m_ready = (DEPTH - q.size()) >= 2;
      chk("res_ready", 32'(rif.res_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("ghr", 32'(ghr), 32'(ref_ghr));
      chk("rd_wr_overlap", 32'(pht_rd_en & pht_wr_en), 32'd0);
      if (q.size() == 0) chk("idle_when_empty", {30'd0, pht_rd_en, pht_wr_en}, 32'd0);
      if (pht_wr_en) begin
        chk("wr_follows_rd", 32'(prev_rd), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          exp_d = ref_train(ref_pht[e.idx], e.taken);
          chk("wr_idx", 32'(pht_wr_idx), 32'(e.idx));
          chk("wr_data", 32'(pht_wr_data), 32'(exp_d));
          ref_pht[e.idx] = exp_d;
          n_wr++;
        end
      end
      if (pht_rd_en && q.size() > 0) chk("rd_idx", 32'(pht_rd_idx), 32'(q[0].idx));
      if (q.size() > 0 && !pht_rd_en && !pht_wr_en) stall++;
      else stall = 0;
      if (q.size() > 0) chk("progress", 32'(stall > 1), 32'd0);
      prev_rd = pht_rd_en;
      if (m_ready && rif.res_valid[0]) begin
        e_new.idx = rif.res_idx0; e_new.taken = rif.res_taken[0]; q.push_back(e_new);
      end
      if (m_ready && rif.res_valid[1]) begin
        e_new.idx = rif.res_idx1; e_new.taken = rif.res_taken[1]; q.push_back(e_new);
      end
      if (m_ready && rif.res_valid[0] && rif.res_mispred[0])
        ref_ghr = GHR_W'((rif.res_ghr0 << 1) | GHR_W'(rif.res_taken[0]));
      else if (m_ready && rif.res_valid[1] && rif.res_mispred[1])
        ref_ghr = GHR_W'((rif.res_ghr1 << 1) | GHR_W'(rif.res_taken[1]));
      else if (pred_valid)
        ref_ghr = GHR_W'((ref_ghr << 1) | GHR_W'(pred_taken));
      if (pl_en) ref_pht[pl_idx] = pl_val;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rif.res_valid = 2'b00; rif.res_idx0 = '0; rif.res_idx1 = '0;
    rif.res_taken = 2'b00; rif.res_mispred = 2'b00; rif.res_ghr0 = '0; rif.res_ghr1 = '0;
    pred_valid = 1'b0; pred_taken = 1'b0;
  endtask

  task automatic preload(input logic [IDX_W-1:0] i, input logic [1:0] v);
    pl_en = 1'b1; pl_idx = i; pl_val = v;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 200) begin cyc(); k++; end
    chk("drained", 32'(busy), 32'd0);
  endtask

  task automatic wait_wr(output logic found, output logic [IDX_W-1:0] i, output logic [1:0] d);
    found = 1'b0; i = '0; d = 2'b00;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (pht_wr_en) begin
        found = 1'b1; i = pht_wr_idx; d = pht_wr_data;
        return;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             f;
    logic [IDX_W-1:0] wi;
    logic [1:0]       wd;
    int               base;
    int               k;

    clear_in();
    rst = 1'b1;
    cyc();
    chk("rst_rd_en", 32'(pht_rd_en), 32'd0);
    chk("rst_wr_en", 32'(pht_wr_en), 32'd0);
    chk("rst_rd_idx", 32'(pht_rd_idx), 32'd0);
    chk("rst_wr_idx", 32'(pht_wr_idx), 32'd0);
    chk("rst_wr_data", 32'(pht_wr_data), 32'd0);
    chk("rst_ready", 32'(rif.res_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ghr", 32'(ghr), 32'd0);
    rst = 1'b0;
    cyc();

    // Single update with exact pipeline timing.
    preload(12'h05A, 2'b01);
    rif.res_valid = 2'b01; rif.res_idx0 = 12'h05A; rif.res_taken = 2'b01;
    cyc();
    clear_in();
    chk("single_idle_after_accept", 32'(pht_rd_en), 32'd0);
    cyc();
    chk("single_rd_en", 32'(pht_rd_en), 32'd1);
    chk("single_rd_idx", 32'(pht_rd_idx), 32'h05A);
    cyc();
    chk("single_wr_en", 32'(pht_wr_en), 32'd1);
    chk("single_wr_idx", 32'(pht_wr_idx), 32'h05A);
    chk("single_wr_data", 32'(pht_wr_data), 32'd2);
    cyc();
    chk("single_busy_fall", 32'(busy), 32'd0);

    // Saturation and in-order training of the same index.
    preload(12'h123, 2'b11);
    rif.res_valid = 2'b11; rif.res_idx0 = 12'h123; rif.res_idx1 = 12'h123; rif.res_taken = 2'b01;
    cyc();
    clear_in();
    wait_wr(f, wi, wd);
    chk("sat_wr0_seen", 32'(f), 32'd1);
    chk("sat_wr0_data", 32'(wd), 32'd3);
    wait_wr(f, wi, wd);
    chk("sat_wr1_seen", 32'(f), 32'd1);
    chk("sat_wr1_data", 32'(wd), 32'd2);
    drain();

    // Fill the FIFO with two back-to-back pairs.
    base = n_wr;
    rif.res_valid = 2'b11; rif.res_idx0 = 12'h200; rif.res_idx1 = 12'h201; rif.res_taken = 2'b01;
    cyc();
    chk("full_ready_after_pair1", 32'(rif.res_ready), 32'd1);
    rif.res_idx0 = 12'h202; rif.res_idx1 = 12'h203; rif.res_taken = 2'b10;
    cyc();
    clear_in();
    chk("full_ready_low", 32'(rif.res_ready), 32'd0);
    k = 0;
    while (!rif.res_ready && k < 20) begin cyc(); k++; end
    chk("full_ready_back", 32'(rif.res_ready), 32'd1);
    chk("full_pops_before_ready", 32'(n_wr - base >= 2), 32'd1);
    drain();
    chk("full_all_written", 32'(n_wr - base), 32'd4);

    // GHR shift, then lane-1 repair over a same-cycle predict.
    pred_valid = 1'b1; pred_taken = 1'b1; cyc();
    pred_taken = 1'b0; cyc();
    pred_taken = 1'b1; cyc();
    pred_valid = 1'b0;
    chk("ghr_shift_101", 32'(ghr), 32'h5);
    base = n_wr;
    rif.res_valid = 2'b10; rif.res_idx1 = 12'h300; rif.res_mispred = 2'b10;
    rif.res_ghr1 = 14'h0003; rif.res_taken = 2'b00; pred_valid = 1'b1; pred_taken = 1'b1;
    cyc();
    clear_in();
    chk("ghr_repair_lane1", 32'(ghr), 32'h6);
    rif.res_valid = 2'b11; rif.res_mispred = 2'b11; rif.res_idx0 = 12'h301; rif.res_idx1 = 12'h302;
    rif.res_ghr0 = 14'h0010; rif.res_ghr1 = 14'h0FFF; rif.res_taken = 2'b01;
    cyc();
    clear_in();
    chk("ghr_dual_mispred", 32'(ghr), 32'h21);
    drain();
    chk("mispred_entries_written", 32'(n_wr - base), 32'd3);

    // Asynchronous reset while a write is in flight.
    rif.res_valid = 2'b11; rif.res_idx0 = 12'h040; rif.res_idx1 = 12'h041; rif.res_taken = 2'b11;
    cyc();
    rif.res_valid = 2'b01; rif.res_idx0 = 12'h042;
    cyc();
    clear_in();
    wait_wr(f, wi, wd);
    chk("rstmid_wr_seen", 32'(f), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_wr_en_drop", 32'(pht_wr_en), 32'd0);
    chk("rstmid_wr_data", 32'(pht_wr_data), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(rif.res_ready), 32'd1);
    chk("rstmid_ghr", 32'(ghr), 32'd0);

    // Random traffic over a small index set so same-index updates collide often.
    for (int n = 0; n < 600; n++) begin
      rif.res_valid   = 2'($urandom_range(0, 3));
      rif.res_idx0    = IDX_W'($urandom_range(0, 7));
      rif.res_idx1    = IDX_W'($urandom_range(0, 7));
      rif.res_taken   = 2'($urandom);
      rif.res_mispred = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rif.res_ghr0    = GHR_W'($urandom);
      rif.res_ghr1    = GHR_W'($urandom);
      pred_valid      = 1'($urandom);
      pred_taken      = 1'($urandom);
      cyc();
    end
    clear_in();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
